// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: sequencer for a bounded train of prescaled high/low pulses
// with pause, abort, busy/done reporting and an async active-low reset.
module pulse_train_ctrl #(
    parameter int DIV_W = 22,
    parameter int CNT_W = 8
) (
    input  logic             clk_in1,
    input  logic             clr_n,
    input  logic             start,
    input  logic             abort,
    input  logic             Enable,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [CNT_W-1:0] n_pulses,
    output logic             Q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             r_state, w_state;
    logic               r_q, w_q, r_done, w_done;
    logic [CNT_W-1:0]   r_left, w_left, r_cnt, w_cnt;
    logic [CNT_W-1:0]   r_on_m1, w_on_m1, r_off_m1, w_off_m1;
    logic [DIV_W-1:0]   r_pre, w_pre, r_div, w_div;
    logic               w_tick, w_seg_end;

    // Segment lengths are stored minus one so a zero length behaves as one tick.
    assign w_tick    = (r_state != IDLE) && Enable && (r_pre == r_div);
    assign w_seg_end = (r_cnt == ((r_state == ON) ? r_on_m1 : r_off_m1));

    always_comb begin
        w_state  = r_state;
        w_q      = r_q;
        w_done   = 1'b0;
        w_left   = r_left;
        w_cnt    = r_cnt;
        w_pre    = r_pre;
        w_div    = r_div;
        w_on_m1  = r_on_m1;
        w_off_m1 = r_off_m1;
        if (abort) begin
            w_state = IDLE;
            w_q     = 1'b0;
            w_left  = '0;
        end else if (r_state == IDLE) begin
            if (start && n_pulses == '0) begin
                w_done = 1'b1;
            end else if (start) begin
                w_state  = ON;
                w_q      = 1'b1;
                w_left   = n_pulses;
                w_cnt    = '0;
                w_pre    = '0;
                w_div    = div;
                w_on_m1  = (on_len == '0) ? '0 : on_len - CNT_W'(1);
                w_off_m1 = (off_len == '0) ? '0 : off_len - CNT_W'(1);
            end
        end else if (w_tick) begin
            w_pre = '0;
            w_cnt = w_seg_end ? '0 : r_cnt + CNT_W'(1);
            if (w_seg_end && r_state == ON) begin
                w_state = OFF;
                w_q     = 1'b0;
                w_left  = r_left - CNT_W'(1);
            end else if (w_seg_end) begin
                w_state = (r_left == '0) ? IDLE : ON;
                w_q     = (r_left != '0);
                w_done  = (r_left == '0);
            end
        end else if (Enable) begin
            w_pre = r_pre + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in1 or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= IDLE;
            r_q      <= 1'b0;
            r_done   <= 1'b0;
            r_left   <= '0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_div    <= '0;
            r_on_m1  <= '0;
            r_off_m1 <= '0;
        end else begin
            r_state  <= w_state;
            r_q      <= w_q;
            r_done   <= w_done;
            r_left   <= w_left;
            r_cnt    <= w_cnt;
            r_pre    <= w_pre;
            r_div    <= w_div;
            r_on_m1  <= w_on_m1;
            r_off_m1 <= w_off_m1;
        end
    end

    assign Q           = r_q;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign pulses_left = r_left;
endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb_pulse_train_ctrl: directed checks of pulse_train_ctrl timing, pause,
// abort, zero-length handling and asynchronous reset.
module tb_pulse_train_ctrl;
    logic        clk_in1, clr_n, start, abort, Enable;
    logic [21:0] div;
    logic [7:0]  on_len, off_len, n_pulses;
    logic        Q, busy, done;
    logic [7:0]  pulses_left;
    int          total, bad, n, h;

    pulse_train_ctrl dut (
        .clk_in1(clk_in1), .clr_n(clr_n), .start(start), .abort(abort),
        .Enable(Enable), .div(div), .on_len(on_len), .off_len(off_len),
        .n_pulses(n_pulses), .Q(Q), .busy(busy), .done(done),
        .pulses_left(pulses_left)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    task automatic step();
        @(posedge clk_in1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive busy samples with Q at the given level, starting at the current one.
    task automatic run_len(input logic lvl, output int cnt);
        cnt = 0;
        while (Q === lvl && busy === 1'b1 && cnt < 1000) begin
            cnt++;
            step();
        end
    endtask

    task automatic cfg(input logic [21:0] d, input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
        div = d; on_len = a; off_len = b; n_pulses = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        clr_n = 1'b0; start = 1'b0; abort = 1'b0; Enable = 1'b1;
        cfg(22'd0, 8'd0, 8'd0, 8'd0);
        #1;
        chk("rst_q", Q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_left", pulses_left, 0);
        step(); step();
        clr_n = 1'b1;
        step();

        cfg(22'd3, 8'd2, 8'd1, 8'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_start_q", Q, 1);
        chk("basic_start_busy", busy, 1);
        chk("basic_start_left", pulses_left, 3);
        h = 0;
        for (int p = 0; p < 3; p++) begin
            run_len(1'b1, n);
            chk("basic_high", n, 8);
            chk("basic_left", pulses_left, 2 - p);
            h += n;
            run_len(1'b0, n);
            chk("basic_low", n, 4);
            h += n;
        end
        chk("basic_busy_total", h, 36);
        chk("basic_done", done, 1);
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_q", Q, 0);

        cfg(22'd0, 8'd0, 8'd0, 8'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_accept_in_done_cycle", busy, 1);
        chk("zero_q0", Q, 1);
        chk("zero_done_low", done, 0);
        step(); chk("zero_q1", Q, 0);
        step(); chk("zero_q2", Q, 1);
        step(); chk("zero_q3", Q, 0);
        step();
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_done_once", done, 0);

        n_pulses = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("np0_done", done, 1);
        chk("np0_busy", busy, 0);
        chk("np0_q", Q, 0);
        step();
        chk("np0_done_once", done, 0);

        cfg(22'd4, 8'd1, 8'd1, 8'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        Enable = 1'b0;
        repeat (7) step();
        chk("pause_hold_q", Q, 1);
        Enable = 1'b1;
        run_len(1'b1, n);
        chk("pause_high", 10 + n - 1, 12);
        run_len(1'b0, n);
        chk("pause_low", n, 5);
        chk("pause_done", done, 1);

        cfg(22'd1, 8'd2, 8'd2, 8'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        run_len(1'b1, n);
        chk("abort_p1_high", n, 4);
        run_len(1'b0, n);
        chk("abort_p1_low", n, 4);
        chk("abort_p2_left", pulses_left, 3);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_q", Q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_left", pulses_left, 0);
        chk("abort_no_done", done, 0);
        step();
        chk("abort_no_done_later", done, 0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_q", Q, 0);
        chk("start_abort_done", done, 0);
        step();
        chk("start_abort_busy_later", busy, 0);

        cfg(22'd2, 8'd3, 8'd1, 8'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_reset_q", Q, 1);
        #2 clr_n = 1'b0;
        #1;
        chk("areset_q", Q, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_left", pulses_left, 0);
        clr_n = 1'b1;
        step();
        cfg(22'd0, 8'd2, 8'd0, 8'd2);
        start = 1'b1;
        step();
        chk("post_q1", Q, 1);
        chk("post_left1", pulses_left, 2);
        n_pulses = 8'd5;
        step(); chk("post_q2", Q, 1); chk("post_left2", pulses_left, 2);
        step(); chk("post_q3", Q, 0); chk("post_left3", pulses_left, 1);
        step(); chk("post_q4", Q, 1); chk("post_left4", pulses_left, 1);
        start = 1'b0;
        step(); chk("post_q5", Q, 1);
        step(); chk("post_q6", Q, 0); chk("post_left6", pulses_left, 0);
        step();
        chk("post_done", done, 1);
        chk("post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_train_ctrl.md
# pulse_train_ctrl

Sequencer for a prescaled toggle output. It generates a programmable train of N high/low pulses on `Q`, with on-time and off-time counted in prescaler ticks. The controller sits between board-level control (switches/buttons or a host FSM) and the LED/GPIO output. It accepts a start request, runs the train autonomously, supports pause and abort, and reports busy/done. It runs on the wizard-generated system clock and replaces free-running toggle dividers wherever a bounded, configurable pattern is needed.

## Interface
- `DIV_W`, 22: prescaler width.
- `CNT_W`, 8: width of on/off lengths and pulse count.

- `clk_in1`  in  1  system clock (post-clock-wizard domain); all logic on rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request to begin a train; sampled only in IDLE.
- `abort`  in  1  terminate the train immediately, from any state.
- `Enable`  in  1  when low, pauses the prescaler and segment counters.
- `div`  in  DIV_W  prescaler terminal count; one tick every div+1 cycles.
- `on_len`  in  CNT_W  high-segment length in ticks; 0 is treated as 1.
- `off_len`  in  CNT_W  low-segment length in ticks; 0 is treated as 1.
- `n_pulses`  in  CNT_W  number of pulses in the train.
- `Q`  out  1  registered pulse output.
- `busy`  out  1  high while a train is in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `pulses_left`  out  CNT_W  pulses not yet finished.

## Operation
- States: IDLE, ON, OFF. `busy` = (state != IDLE).
- Reset (`clr_n`=0, async) forces: state IDLE, `Q`=0, `busy`=0, `done`=0, `pulses_left`=0, prescaler=0, segment count=0.
- Start acceptance: requires IDLE, `start`=1, `abort`=0, `n_pulses`≠0.
  - On acceptance, latch `div`, effective on_len, effective off_len and `n_pulses`.
  - Clear the prescaler and segment count.
  - Next state ON, `Q`=1.
- `start` with `n_pulses`=0 in IDLE: stay IDLE, `Q` stays 0, `done`=1 for one cycle.
- `start` while busy is ignored. Configuration inputs are ignored after latching.
- Tick = busy & `Enable` & (prescaler == latched div).
  - On a tick the prescaler wraps to 0.
  - When busy and `Enable`=1 but not a tick, the prescaler increments.
- In ON, each tick increments the segment count. When the count reaches on_len-1, the tick instead:
  - zeroes the count,
  - moves to OFF,
  - sets `Q`=0,
  - decrements `pulses_left`.
- In OFF, when the count reaches off_len-1, the tick:
  - if `pulses_left`=0: moves to IDLE and pulses `done`=1 for one cycle;
  - otherwise: moves to ON and sets `Q`=1.
- `Enable`=0: prescaler, segment count, state and `Q` all hold. Resuming continues exactly where it paused.
- `abort`=1: next state IDLE, `Q`=0, `pulses_left`=0, no `done`.
  - Abort has priority over ticks and over `start` in the same cycle.
  - Abort in IDLE is a no-op.
- `done` is asserted only on normal completion and is never high while `busy`=1.

## Timing
- Start sampled at edge t: `busy`=1 and `Q`=1 from cycle t+1.
- With `Enable` held high, D=div, A=eff on_len, B=eff off_len:
  - `Q` is high for exactly A·(D+1) cycles, then low for B·(D+1) cycles, per pulse.
  - Total busy time is N·(A+B)·(D+1) cycles.
- `done` and `busy`=0 appear in the cycle after the final OFF tick.
  - A new `start` can be accepted in that same cycle.
- Every cycle with `Enable`=0 extends the current segment by one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Arithmetic:
  - The prescaler compares for equality and never overflows past div.
  - div=0 gives a tick every cycle.

## Test plan
- Basic train: div=3, on_len=2, off_len=1, n_pulses=3, start for 1 cycle.
  - `Q` high 8 cycles, low 4 cycles, repeated 3 times.
  - `busy` high 36 cycles, `done` one cycle after, `pulses_left` counts 3→2→1→0.
- Zero-length fields: on_len=0, off_len=0, div=0, n_pulses=2 → `Q` pattern 1,0,1,0, then `done`.
- n_pulses=0 with start → no `busy`, `Q`=0, single `done` pulse next cycle.
- Pause: div=4, on_len=1. Drop `Enable` for 7 cycles mid-ON → that ON segment lasts 5+7=12 cycles and the OFF timing is unchanged.
- Abort: during pulse 2 of 4, assert `abort`, with `start` also high in a later IDLE cycle combined with abort.
  - `Q`=0, `busy`=0, `pulses_left`=0 the next cycle.
  - No `done`; the start+abort combination is not accepted.
- Async reset mid-ON: drop `clr_n` between edges → all outputs 0 immediately. After release, a start with a new config runs cleanly, and a start asserted while busy is ignored.
